// File: rtl/lcd_arbiter_pkg.sv
// Shared definitions for the LCD command arbiter: FSM states, HD44780-style
// command constants and the round-robin pick used when both ports request.
package lcd_arbiter_pkg;

   localparam int CMD_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RTZ  = 2'd2
   } state_t;

   localparam logic [CMD_W-1:0] FUNC_SET = 9'h028;
   localparam logic [CMD_W-1:0] ENTRY    = 9'h006;
   localparam logic [CMD_W-1:0] DISP_ON  = 9'h00C;
   localparam logic [CMD_W-1:0] CLEAR    = 9'h001;
   localparam logic [CMD_W-1:0] HOME     = 9'h080;
   localparam logic [CMD_W-1:0] LINE_2   = 9'h0C0;
   localparam logic [CMD_W-1:0] DATA_RS  = 9'h100;

   // A lone requester wins outright; a tie goes to the port not served last.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      return (req == 2'b11) ? ~last : req[1];
   endfunction

endpackage

// File: rtl/lcd_arbiter.sv
// Shares one lcd_ctrl driver between the refresh sequencer (port 0) and the
// bus command path (port 1) using four-phase write/ack on every side.
module lcd_arbiter
   import lcd_arbiter_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [CMD_W-1:0] r0_command,
   input  logic             r0_write,
   input  logic             r0_lock,
   output logic             r0_ack,
   input  logic [CMD_W-1:0] r1_command,
   input  logic             r1_write,
   input  logic             r1_lock,
   output logic             r1_ack,
   output logic [CMD_W-1:0] lcd_command,
   output logic             lcd_write,
   input  logic             lcd_ack,
   output logic             busy,
   output logic             owner
);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             locked_q, locked_d;
   logic             lcd_write_q, lcd_write_d;
   logic [CMD_W-1:0] lcd_command_q, lcd_command_d;
   logic [1:0]       ack_q, ack_d;

   logic [1:0]       req;
   logic [1:0]       lock;
   logic             grant_port;
   logic [CMD_W-1:0] grant_cmd;

   assign req  = {r1_write, r0_write};
   assign lock = {r1_lock, r0_lock};

   // While locked only the current owner is eligible.
   assign grant_port = locked_q ? owner_q : rr_pick(req, last_q);
   assign grant_cmd  = grant_port ? r1_command : r0_command;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      locked_d      = locked_q;
      lcd_write_d   = lcd_write_q;
      lcd_command_d = lcd_command_q;
      ack_d         = ack_q;
      case (state_q)
         ST_IDLE: begin
            if (!lcd_ack) begin
               if (req[grant_port]) begin
                  lcd_command_d = grant_cmd;
                  lcd_write_d   = 1'b1;
                  owner_d       = grant_port;
                  last_d        = grant_port;
                  locked_d      = lock[grant_port];
                  state_d       = ST_XFER;
               end else if (locked_q && !lock[owner_q]) begin
                  locked_d = 1'b0;
               end
            end
         end
         ST_XFER: begin
            if (lcd_ack) begin
               lcd_write_d = 1'b0;
               ack_d       = owner_q ? 2'b10 : 2'b01;
               state_d     = ST_RTZ;
            end
         end
         ST_RTZ: begin
            // Release only once both the owner and the driver have returned to zero.
            if (!req[owner_q] && !lcd_ack) begin
               ack_d    = 2'b00;
               locked_d = lock[owner_q];
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         last_q        <= 1'b1;
         locked_q      <= 1'b0;
         lcd_write_q   <= 1'b0;
         lcd_command_q <= '0;
         ack_q         <= 2'b00;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         locked_q      <= locked_d;
         lcd_write_q   <= lcd_write_d;
         lcd_command_q <= lcd_command_d;
         ack_q         <= ack_d;
      end
   end

   assign lcd_command = lcd_command_q;
   assign lcd_write   = lcd_write_q;
   assign r0_ack      = ack_q[0];
   assign r1_ack      = ack_q[1];
   assign busy        = (state_q != ST_IDLE);
   assign owner       = owner_q;

endmodule
